// File: rtl/int_to_fp_issue_arbiter.sv
// Round-robin sharing of one pipelined IntToFP unit between two issue ports.
// A LATENCY-deep tracker follows each issued op so its result returns to the right requester.
module int_to_fp_issue_arbiter #(
  parameter int LATENCY = 2,
  parameter int ID_W    = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [1:0]                     req_valid,
  output logic [1:0]                     req_ready,
  input  logic [127:0]                   req_in1,
  input  logic [15:0]                    req_ctrl,
  input  logic [2*ID_W-1:0]              req_id,
  input  logic [1:0]                     kill,
  output logic                           fu_in_valid,
  output logic [63:0]                    fu_in_bits_in1,
  output logic [7:0]                     fu_in_bits_ctrl,
  input  logic                           fu_out_valid,
  input  logic [63:0]                    fu_out_data,
  input  logic [3:0]                     fu_out_exc,
  output logic [1:0]                     resp_valid,
  output logic [63:0]                    resp_data,
  output logic [3:0]                     resp_exc,
  output logic [ID_W-1:0]                resp_id,
  output logic [$clog2(LATENCY+1)-1:0]   inflight,
  output logic                           err
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [1:0]         elig_s;
  logic [1:0]         grant_s;
  logic               gnt_port_s;
  logic               any_grant_s;
  logic [ID_W-1:0]    issue_id_s;
  logic               rr_last_r;

  logic [LATENCY-1:0] stg_valid_r;
  logic [LATENCY-1:0] stg_issued_r;
  logic [LATENCY-1:0] stg_port_r;
  logic [ID_W-1:0]    stg_id_r [LATENCY];

  logic               tail_valid_s;
  logic               tail_issued_s;
  logic               tail_port_s;
  logic [ID_W-1:0]    tail_id_s;
  logic               resp_hit_s;

  logic [CNT_W-1:0]   sup_cnt_r;
  logic               err_r;

  function automatic logic [CNT_W-1:0] count_valid(input logic [LATENCY-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < LATENCY; k++) begin
      n = n + CNT_W'(v[k]);
    end
    return n;
  endfunction

  // Arbitration: killed ports are ineligible; on a tie the port that did not win last goes.
  always_comb begin
    elig_s     = req_valid & ~kill;
    grant_s    = 2'b00;
    gnt_port_s = 1'b0;
    if (reset) begin
      grant_s    = 2'b00;
      gnt_port_s = 1'b0;
    end else begin
      case (elig_s)
        2'b01: begin
          grant_s    = 2'b01;
          gnt_port_s = 1'b0;
        end
        2'b10: begin
          grant_s    = 2'b10;
          gnt_port_s = 1'b1;
        end
        2'b11: begin
          if (rr_last_r) begin
            grant_s    = 2'b01;
            gnt_port_s = 1'b0;
          end else begin
            grant_s    = 2'b10;
            gnt_port_s = 1'b1;
          end
        end
        default: begin
          grant_s    = 2'b00;
          gnt_port_s = 1'b0;
        end
      endcase
    end
  end

  assign any_grant_s = |grant_s;
  assign req_ready   = grant_s;

  // Issue mux: the granted port's operand and controls go straight to the unit.
  always_comb begin
    fu_in_valid     = 1'b0;
    fu_in_bits_in1  = 64'd0;
    fu_in_bits_ctrl = 8'd0;
    issue_id_s      = '0;
    if (any_grant_s) begin
      fu_in_valid     = 1'b1;
      fu_in_bits_in1  = gnt_port_s ? req_in1[127:64] : req_in1[63:0];
      fu_in_bits_ctrl = gnt_port_s ? req_ctrl[15:8]  : req_ctrl[7:0];
      issue_id_s      = gnt_port_s ? req_id[2*ID_W-1:ID_W] : req_id[ID_W-1:0];
    end else begin
      fu_in_valid     = 1'b0;
      fu_in_bits_in1  = 64'd0;
      fu_in_bits_ctrl = 8'd0;
      issue_id_s      = '0;
    end
  end

  assign tail_valid_s  = stg_valid_r[LATENCY-1];
  assign tail_issued_s = stg_issued_r[LATENCY-1];
  assign tail_port_s   = stg_port_r[LATENCY-1];
  assign tail_id_s     = stg_id_r[LATENCY-1];

  // Tracker shift register; issued survives a kill so the error check still expects the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stg_valid_r  <= '0;
      stg_issued_r <= '0;
      stg_port_r   <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        stg_id_r[k] <= '0;
      end
      rr_last_r    <= 1'b1;
    end else begin
      stg_valid_r[0]  <= any_grant_s & ~kill[gnt_port_s];
      stg_issued_r[0] <= any_grant_s;
      stg_port_r[0]   <= gnt_port_s;
      stg_id_r[0]     <= issue_id_s;
      for (int k = 1; k < LATENCY; k++) begin
        stg_valid_r[k]  <= stg_valid_r[k-1] & ~kill[stg_port_r[k-1]];
        stg_issued_r[k] <= stg_issued_r[k-1];
        stg_port_r[k]   <= stg_port_r[k-1];
        stg_id_r[k]     <= stg_id_r[k-1];
      end
      if (any_grant_s) begin
        rr_last_r <= gnt_port_s;
      end else begin
        rr_last_r <= rr_last_r;
      end
    end
  end

  // Response steering from the tracker tail; a kill this cycle drops the result.
  always_comb begin
    resp_hit_s = ~reset & tail_valid_s & fu_out_valid & ~kill[tail_port_s];
    resp_valid = 2'b00;
    resp_data  = 64'd0;
    resp_exc   = 4'd0;
    resp_id    = '0;
    if (resp_hit_s) begin
      resp_valid = tail_port_s ? 2'b10 : 2'b01;
      resp_data  = fu_out_data;
      resp_exc   = fu_out_exc;
      resp_id    = tail_id_s;
    end else begin
      resp_valid = 2'b00;
      resp_data  = 64'd0;
      resp_exc   = 4'd0;
      resp_id    = '0;
    end
  end

  // Sticky tracker/unit disagreement flag, blind while pre-reset results may still drain out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sup_cnt_r <= CNT_W'(LATENCY);
      err_r     <= 1'b0;
    end else if (sup_cnt_r != '0) begin
      sup_cnt_r <= sup_cnt_r - CNT_W'(1);
      err_r     <= err_r;
    end else begin
      sup_cnt_r <= sup_cnt_r;
      err_r     <= err_r | (fu_out_valid ^ tail_issued_s);
    end
  end

  assign inflight = count_valid(stg_valid_r);
  assign err      = err_r;

endmodule
